// File: rtl/dimension_parser.sv
// dimension_parser: turns an ASCII stream of "<L>x<W>x<H>\n" lines into
// registered dimension triples with a one-cycle size_valid strobe.
// Malformed lines are dropped and raise a sticky parse_error.
module dimension_parser #(
  parameter int SIZE_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   end_of_input,
  output logic                   size_valid,
  output logic [SIZE_WIDTH-1:0]  length,
  output logic [SIZE_WIDTH-1:0]  width,
  output logic [SIZE_WIDTH-1:0]  height,
  output logic [COUNT_WIDTH-1:0] triple_count,
  output logic                   parse_error
);

  localparam logic [1:0] FIELD_L = 2'd0;
  localparam logic [1:0] FIELD_W = 2'd1;
  localparam logic [1:0] FIELD_H = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_X  = 8'h78;

  logic [1:0]             state_q, state_d;
  logic [SIZE_WIDTH-1:0]  acc_q, acc_d;
  logic                   seen_q, seen_d;
  logic [SIZE_WIDTH-1:0]  l_pend_q, l_pend_d;
  logic [SIZE_WIDTH-1:0]  w_pend_q, w_pend_d;
  logic [SIZE_WIDTH-1:0]  len_q, len_d;
  logic [SIZE_WIDTH-1:0]  wid_q, wid_d;
  logic [SIZE_WIDTH-1:0]  hgt_q, hgt_d;
  logic                   sv_q, sv_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic is_digit;
  logic line_end;

  // '0'..'9' carry their value in the low nibble
  assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
  // end_of_input behaves exactly like a newline
  assign line_end = end_of_input || (byte_valid && (byte_data == CH_LF));

  // Next-state decode: one byte (or flush) per cycle
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    seen_d   = seen_q;
    l_pend_d = l_pend_q;
    w_pend_d = w_pend_q;
    len_d    = len_q;
    wid_d    = wid_q;
    hgt_d    = hgt_q;
    sv_d     = 1'b0;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (line_end) begin
      // every line terminator restarts at a fresh length field
      state_d = FIELD_L;
      acc_d   = '0;
      seen_d  = 1'b0;
      if (state_q == FIELD_H && seen_q) begin
        len_d = l_pend_q;
        wid_d = w_pend_q;
        hgt_d = acc_q;
        sv_d  = 1'b1;
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end else if (!(state_q == DISCARD || (state_q == FIELD_L && !seen_q))) begin
        err_d = 1'b1;
      end
    end else if (byte_valid && byte_data != CH_CR && state_q != DISCARD) begin
      if (is_digit) begin
        acc_d  = acc_q * SIZE_WIDTH'(10) + SIZE_WIDTH'(byte_data[3:0]);
        seen_d = 1'b1;
      end else if (byte_data == CH_X && seen_q && state_q != FIELD_H) begin
        if (state_q == FIELD_L) begin
          l_pend_d = acc_q;
          state_d  = FIELD_W;
        end else begin
          w_pend_d = acc_q;
          state_d  = FIELD_H;
        end
        acc_d  = '0;
        seen_d = 1'b0;
      end else begin
        // bad character or misplaced 'x': skip the rest of the line
        err_d   = 1'b1;
        state_d = DISCARD;
        acc_d   = '0;
        seen_d  = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FIELD_L;
      acc_q    <= '0;
      seen_q   <= 1'b0;
      l_pend_q <= '0;
      w_pend_q <= '0;
      len_q    <= '0;
      wid_q    <= '0;
      hgt_q    <= '0;
      sv_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      seen_q   <= seen_d;
      l_pend_q <= l_pend_d;
      w_pend_q <= w_pend_d;
      len_q    <= len_d;
      wid_q    <= wid_d;
      hgt_q    <= hgt_d;
      sv_q     <= sv_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign size_valid   = sv_q;
  assign length       = len_q;
  assign width        = wid_q;
  assign height       = hgt_q;
  assign triple_count = cnt_q;
  assign parse_error  = err_q;

endmodule

// File: tb/tb_dimension_parser.sv
// Bench for dimension_parser: a 16-bit and an 8-bit instance share one input
// stream; a line-level reference model predicts every cycle of both.
module tb_dimension_parser;
  typedef logic [7:0] u8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic end_of_input = 1'b0;

  logic        sv16, sv8, err16, err8;
  logic [15:0] l16, w16, h16, c16, c8;
  logic [7:0]  l8, w8, h8;

  dimension_parser #(.SIZE_WIDTH(16), .COUNT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .end_of_input(end_of_input), .size_valid(sv16), .length(l16), .width(w16),
    .height(h16), .triple_count(c16), .parse_error(err16));

  dimension_parser #(.SIZE_WIDTH(8), .COUNT_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .end_of_input(end_of_input), .size_valid(sv8), .length(l8), .width(w8),
    .height(h8), .triple_count(c8), .parse_error(err8));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc[$];

  // reference model state
  u8   line_q[$];
  bit  line_bad;
  bit  m_sv, m_err;
  int  m_cnt;
  int  m16[3];
  int  m8[3];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_dig(input u8 c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // 0 = cannot become a valid line, 1 = valid prefix, 2 = complete, 3 = empty
  function automatic int classify(input u8 ln[$]);
    int nx = 0;
    int flen = 0;
    bit any = 0;
    for (int i = 0; i < ln.size(); i++) begin
      if (ln[i] == 8'h0D) continue;
      any = 1;
      if (is_dig(ln[i])) flen++;
      else if (ln[i] == 8'h78) begin
        if (flen == 0 || nx == 2) return 0;
        nx++;
        flen = 0;
      end else return 0;
    end
    if (!any) return 3;
    if (nx == 2 && flen > 0) return 2;
    return 1;
  endfunction

  function automatic void model_reset();
    line_q.delete();
    line_bad = 0;
    m_sv = 0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin m16[i] = 0; m8[i] = 0; end
  endfunction

  function automatic void model_emit();
    int f = 0;
    for (int i = 0; i < 3; i++) begin m16[i] = 0; m8[i] = 0; end
    for (int i = 0; i < line_q.size(); i++) begin
      if (is_dig(line_q[i])) begin
        m16[f] = (m16[f] * 10 + int'(line_q[i]) - 48) % 65536;
        m8[f]  = (m8[f]  * 10 + int'(line_q[i]) - 48) % 256;
      end else if (line_q[i] == 8'h78) f++;
    end
    m_sv = 1;
    m_cnt = (m_cnt + 1) % 65536;
  endfunction

  function automatic void model_step(input bit bv, input u8 d, input bit e);
    int k;
    m_sv = 0;
    if (e || (bv && d == 8'h0A)) begin
      if (!line_bad) begin
        k = classify(line_q);
        if (k == 2) model_emit();
        else if (k == 1) m_err = 1;
      end
      line_q.delete();
      line_bad = 0;
    end else if (bv && !line_bad) begin
      line_q.push_back(d);
      if (classify(line_q) == 0) begin
        m_err = 1;
        line_bad = 1;
      end
    end
  endfunction

  task automatic check_all();
    chk("sv16", sv16, m_sv);
    chk("cnt16", c16, m_cnt);
    chk("err16", err16, m_err);
    chk("len16", l16, m16[0]);
    chk("wid16", w16, m16[1]);
    chk("hgt16", h16, m16[2]);
    chk("sv8", sv8, m_sv);
    chk("err8", err8, m_err);
    chk("len8", l8, m8[0]);
    chk("dims8", {w8, h8}, {8'(m8[1]), 8'(m8[2])});
  endtask

  // one clock: drive, sample edge, compare #1 later
  task automatic step(input bit bv, input u8 d, input bit e);
    byte_valid = bv; byte_data = d; end_of_input = e;
    @(posedge clk);
    if (!rst) model_step(bv, d, e);
    #1;
    cyc++;
    check_all();
    if (sv16) begin pulses++; pulse_cyc.push_back(cyc); end
    byte_valid = 0; end_of_input = 0;
  endtask

  task automatic hold_reset(input int n);
    #1 rst = 1;
    model_reset();
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
    rst = 0;
    pulses = 0;
    pulse_cyc.delete();
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(1, s[i], 0);
  endtask

  typedef struct {
    string stim;
    bit    eoi;
    int    exp_pulses;
    int    exp_l, exp_w, exp_h;
    bit    exp_err;
    int    exp_l8;
  } vec_t;

  vec_t vecs[7];

  initial begin
    string junk;
    string s;
    int    r;
    vecs[0] = '{"2x3x4\n",                 0, 1,    2,  3,  4, 0,   2};
    vecs[1] = '{"1x1x10\r\n29x13x26\n",    0, 2,   29, 13, 26, 0,  29};
    vecs[2] = '{"3x4\n5x5x5\n",            0, 1,    5,  5,  5, 1,   5};
    vecs[3] = '{"\n\n7x8x9",               1, 1,    7,  8,  9, 0,   7};
    vecs[4] = '{"300x2x1\n",               0, 1,  300,  2,  1, 0,  44};
    vecs[5] = '{"1x2x3x4\n",               0, 0,    0,  0,  0, 1,   0};
    vecs[6] = '{"70000x1x1\n",             0, 1, 4464,  1,  1, 0, 112};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sv", sv16, 0);
    chk("rst_len", l16, 0);
    chk("rst_cnt", c16, 0);
    chk("rst_err", err16, 0);
    rst = 0;

    // table vectors from a clean reset each
    for (int v = 0; v < 7; v++) begin
      hold_reset(2);
      feed(vecs[v].stim);
      if (vecs[v].eoi) step(0, 8'h00, 1);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      chk($sformatf("v%0d_pulses", v), pulses, vecs[v].exp_pulses);
      chk($sformatf("v%0d_cnt", v), c16, vecs[v].exp_pulses);
      chk($sformatf("v%0d_l", v), l16, vecs[v].exp_l);
      chk($sformatf("v%0d_w", v), w16, vecs[v].exp_w);
      chk($sformatf("v%0d_h", v), h16, vecs[v].exp_h);
      chk($sformatf("v%0d_err", v), err16, vecs[v].exp_err);
      chk($sformatf("v%0d_l8", v), l8, vecs[v].exp_l8);
    end

    // eoi pulse lands exactly one cycle after the flush strobe
    hold_reset(2);
    feed("\n\n7x8x9");
    step(0, 8'h00, 1);
    chk("eoi_latency", sv16, 1);

    // back-to-back minimal lines: pulses 6 cycles apart
    hold_reset(2);
    feed("1x1x1\n1x1x1\n1x1x1\n");
    step(0, 8'h00, 0);
    chk("b2b_pulses", pulses, 3);
    if (pulses == 3) begin
      chk("b2b_gap0", pulse_cyc[1] - pulse_cyc[0], 6);
      chk("b2b_gap1", pulse_cyc[2] - pulse_cyc[1], 6);
    end

    // reset mid-line loses the partial line
    hold_reset(2);
    feed("12x3");
    hold_reset(2);
    feed("4x5x6\n");
    step(0, 8'h00, 0);
    chk("rstmid_pulses", pulses, 1);
    chk("rstmid_cnt", c16, 1);
    chk("rstmid_dims", {l16, w16, h16}, {16'd4, 16'd5, 16'd6});

    // idle gaps inside a line do not disturb it
    hold_reset(2);
    feed("4x");
    repeat (3) step(0, 8'h00, 0);
    feed("5x6\n");
    step(0, 8'h00, 0);
    chk("gap_dims", {l16, w16, h16}, {16'd4, 16'd5, 16'd6});
    chk("gap_err", err16, 0);

    // randomized line stream against the model
    hold_reset(2);
    junk = "0123456789xx\r\n ab";
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)
        s = $sformatf("%0dx%0dx%0d",
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99999) : $urandom_range(0, 99),
                      $urandom_range(0, 999), $urandom_range(0, 300));
      else if (r == 7) begin
        s = "";
        for (int i = 0; i < $urandom_range(1, 8); i++)
          s = {s, string'(junk[$urandom_range(0, junk.len() - 1)])};
      end else
        s = $sformatf("%0dx%0d", $urandom_range(0, 99), $urandom_range(0, 99));
      if ($urandom_range(0, 99) == 0) hold_reset(1 + $urandom_range(0, 1));
      for (int i = 0; i < s.len(); i++) begin
        while ($urandom_range(0, 4) == 0) step(0, 8'h00, 0);
        step(1, s[i], 0);
      end
      if ($urandom_range(0, 9) == 0) step(0, 8'h00, 1);
      else begin
        if ($urandom_range(0, 4) == 0) step(1, 8'h0D, 0);
        step(1, 8'h0A, 0);
      end
    end
    step(0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dimension_parser.md
# dimension_parser

Upstream front end for the per-box length pipeline. Consumes the puzzle input as a stream of ASCII bytes, one line per box in the form `<L>x<W>x<H>\n`, and emits one registered dimension triple per completed line with a single-cycle `size_valid` strobe. The output port set matches the dimension input of the downstream length computation stage, which is always ready, so there is no backpressure.

## Interface
- `SIZE_WIDTH`, default 16: width of each decoded dimension.
- `COUNT_WIDTH`, default 16: width of the emitted-triple counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `byte_valid`  in  1  `byte_data` is valid this cycle; may assert every cycle.
- `byte_data`  in  8  ASCII input character.
- `end_of_input`  in  1  single-cycle strobe after the last byte; flushes an unterminated final line. Never coincident with `byte_valid`.
- `size_valid`  out  1  one-cycle pulse; `length`/`width`/`height` hold a new triple.
- `length`, `width`, `height`  out  SIZE_WIDTH each  decoded dimensions; held until the next pulse.
- `triple_count`  out  COUNT_WIDTH  number of triples emitted since reset; wraps modulo 2^COUNT_WIDTH.
- `parse_error`  out  1  sticky; set on any malformed line; cleared only by `rst`.

## Operation
- States: `FIELD_L`, `FIELD_W`, `FIELD_H`, `DISCARD`.
- Each field state has an accumulator `acc` and a `seen_digit` flag. Both are cleared on entry.
- Digit `'0'..'9'` in a field state: `acc <= SIZE_WIDTH'(acc*10 + (byte-8'h30))`, which wraps silently. Also set `seen_digit`.
- `'x'` (0x78):
  - In `FIELD_L` or `FIELD_W` with `seen_digit`: latch `acc` into the pending field and advance to the next state.
  - In `FIELD_H`, or with no digit seen: set `parse_error` and go to `DISCARD`.
- `'\n'` (0x0A):
  - In `FIELD_H` with `seen_digit`: emit the triple, increment `triple_count`, go to `FIELD_L`.
  - In `FIELD_L` with no digit (empty line): ignore and stay in `FIELD_L`.
  - Any other field-state case: set `parse_error`, drop the line, go to `FIELD_L`.
  - In `DISCARD`: go to `FIELD_L`.
- `'\r'` (0x0D): ignored in every state.
- Any other byte in a field state: set `parse_error` and go to `DISCARD`. In `DISCARD`, every byte except `'\n'` is ignored.
- `end_of_input`:
  - Handled as if a `'\n'` arrived in the current state, with identical emit and error rules.
  - In `FIELD_L` with no digit it does nothing.
  - The FSM ends in `FIELD_L`.
- `byte_valid`=0: no state change.

## Timing
- Reset values:
  - state `FIELD_L`
  - all accumulators and `seen_digit` 0
  - `size_valid`=0, `length`=`width`=`height`=0
  - `triple_count`=0, `parse_error`=0
- Latency: `size_valid` is asserted in the cycle after the terminating `'\n'` (or `end_of_input`) is sampled. The triple on `length`/`width`/`height` is valid in that same cycle.
- `size_valid` is high for exactly one cycle per line. Back-to-back minimal lines at one byte per cycle (`1x1x1\n`, 6 bytes) give pulses 6 cycles apart. No throughput limit: the parser accepts a byte every cycle.
- `length`/`width`/`height` change only on a `size_valid` cycle; otherwise they hold.
- `triple_count` updates in the same cycle as `size_valid`.
- `parse_error` rises in the cycle after the offending byte.
- Reset asserted mid-line: the partial line is lost, and no pulse is produced after release. The first byte after release starts a new line.
- A digit immediately after emission (next cycle) is accepted normally.

## Test plan
- `2x3x4\n` at one byte per cycle -> one pulse the cycle after `'\n'` with L=2, W=3, H=4; `triple_count`=1; `parse_error`=0.
- `1x1x10\r\n29x13x26\n` back-to-back -> two pulses, (1,1,10) then (29,13,26); `triple_count`=2; no error.
- `3x4\n5x5x5\n` -> no pulse for the first line and `parse_error`=1; second line emits (5,5,5); error stays set.
- `\n\n7x8x9` then `end_of_input` -> empty lines ignored; pulse (7,8,9) one cycle after `end_of_input`; `parse_error`=0.
- With SIZE_WIDTH=8: `300x2x1\n` -> pulse with L=44 (300 mod 256), W=2, H=1; no error.
- `12x3` followed by `rst` for 2 cycles, then `4x5x6\n` -> no pulse for the aborted line; pulse (4,5,6); `triple_count`=1.
